// File: rtl/audio_tone_mixer.sv
// audio_tone_mixer: NUM_TONES square-wave tones mixed onto codec samples.
// Define AUDIO_TONE_MIXER_SAT_EN to saturate the mix instead of wrapping.
module audio_tone_mixer #(
  parameter int SAMPLE_W  = 32,
  parameter int NUM_TONES = 4,
  parameter int PERIOD_W  = 19
) (
  input  logic                            CLOCK_50,
  input  logic                            reset_n,
  input  logic [NUM_TONES*PERIOD_W-1:0]   tone_half_period,
  input  logic [NUM_TONES*(SAMPLE_W-1)-1:0] tone_amplitude,
  input  logic [2*NUM_TONES-1:0]          tone_route,
  input  logic                            passthru_en,
  input  logic                            audio_in_available,
  input  logic                            audio_out_allowed,
  input  logic [SAMPLE_W-1:0]             left_channel_audio_in,
  input  logic [SAMPLE_W-1:0]             right_channel_audio_in,
  output logic                            read_audio_in,
  output logic                            write_audio_out,
  output logic [SAMPLE_W-1:0]             left_channel_audio_out,
  output logic [SAMPLE_W-1:0]             right_channel_audio_out,
  output logic                            busy
);

  localparam int ACC_W = SAMPLE_W + $clog2(NUM_TONES + 1);
  localparam int AMP_W = SAMPLE_W - 1;
  localparam int EXT_W = ACC_W - SAMPLE_W;
  localparam int IDX_W = (NUM_TONES > 1) ? $clog2(NUM_TONES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_TONES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    CLAMP,
    XFER
  } state_t;

  state_t state_q, state_d;

  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [NUM_TONES-1:0] snap_q, snap_d;
  logic [NUM_TONES-1:0] pol;
  logic [ACC_W-1:0]     acc_l_q, acc_l_d;
  logic [ACC_W-1:0]     acc_r_q, acc_r_d;
  logic [SAMPLE_W-1:0]  out_l_q, out_l_d;
  logic [SAMPLE_W-1:0]  out_r_q, out_r_d;
  logic                 stb_q, stb_d;

  logic [PERIOD_W-1:0]  hp_a  [NUM_TONES];
  logic [AMP_W-1:0]     amp_a [NUM_TONES];

  genvar k;
  generate
    for (k = 0; k < NUM_TONES; k++) begin : g_tone
      logic [PERIOD_W-1:0] cnt_q;
      logic                pol_q;

      assign hp_a[k]  = tone_half_period[k*PERIOD_W +: PERIOD_W];
      assign amp_a[k] = tone_amplitude[k*AMP_W +: AMP_W];
      assign pol[k]   = pol_q;

      // Free-running half-period counter; >= lets a shrunk period wrap at once.
      always_ff @(posedge CLOCK_50) begin
        if (!reset_n || hp_a[k] == '0) begin
          cnt_q <= '0;
          pol_q <= 1'b0;
        end else if (cnt_q >= hp_a[k]) begin
          cnt_q <= '0;
          pol_q <= ~pol_q;
        end else begin
          cnt_q <= cnt_q + PERIOD_W'(1);
        end
      end
    end
  endgenerate

  logic             hp_nz;
  logic             add_l, add_r;
  logic [ACC_W-1:0] mag, contrib;

  // Signed contribution of the channel selected by idx.
  always_comb begin
    hp_nz   = |hp_a[idx_q];
    add_l   = hp_nz & tone_route[{idx_q, 1'b0}];
    add_r   = hp_nz & tone_route[{idx_q, 1'b1}];
    mag     = ACC_W'(amp_a[idx_q]);
    contrib = snap_q[idx_q] ? mag : (~mag + ACC_W'(1));
  end

  logic [SAMPLE_W-1:0] red_l, red_r;

`ifdef AUDIO_TONE_MIXER_SAT_EN
  localparam logic [SAMPLE_W-1:0] S_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic [SAMPLE_W-1:0] S_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};
  logic ovf_l, ovf_r;

  // Out of range when the top bits are not all copies of the sign.
  always_comb begin
    ovf_l = ~((&acc_l_q[ACC_W-1:SAMPLE_W-1]) | ~(|acc_l_q[ACC_W-1:SAMPLE_W-1]));
    ovf_r = ~((&acc_r_q[ACC_W-1:SAMPLE_W-1]) | ~(|acc_r_q[ACC_W-1:SAMPLE_W-1]));
    red_l = acc_l_q[SAMPLE_W-1:0];
    red_r = acc_r_q[SAMPLE_W-1:0];
    if (ovf_l) red_l = acc_l_q[ACC_W-1] ? S_MIN : S_MAX;
    if (ovf_r) red_r = acc_r_q[ACC_W-1] ? S_MIN : S_MAX;
  end
`else
  assign red_l = acc_l_q[SAMPLE_W-1:0];
  assign red_r = acc_r_q[SAMPLE_W-1:0];
`endif

  logic xfer_ok;
  assign xfer_ok = audio_in_available & audio_out_allowed;

  // Capture, serial accumulate, reduce, then hand off one pop/push pair.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    acc_l_d = acc_l_q;
    acc_r_d = acc_r_q;
    out_l_d = out_l_q;
    out_r_d = out_r_q;
    stb_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (xfer_ok) begin
          acc_l_d = '0;
          acc_r_d = '0;
          if (passthru_en) begin
            acc_l_d = {{EXT_W{left_channel_audio_in[SAMPLE_W-1]}},
                       left_channel_audio_in};
            acc_r_d = {{EXT_W{right_channel_audio_in[SAMPLE_W-1]}},
                       right_channel_audio_in};
          end
          snap_d  = pol;
          idx_d   = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        if (add_l) acc_l_d = acc_l_q + contrib;
        if (add_r) acc_r_d = acc_r_q + contrib;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST) begin
          idx_d   = '0;
          state_d = CLAMP;
        end
      end
      CLAMP: begin
        out_l_d = red_l;
        out_r_d = red_r;
        state_d = XFER;
      end
      XFER: begin
        if (xfer_ok) begin
          stb_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      snap_q  <= '0;
      acc_l_q <= '0;
      acc_r_q <= '0;
      out_l_q <= '0;
      out_r_q <= '0;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      acc_l_q <= acc_l_d;
      acc_r_q <= acc_r_d;
      out_l_q <= out_l_d;
      out_r_q <= out_r_d;
      stb_q   <= stb_d;
    end
  end

  assign read_audio_in           = stb_q;
  assign write_audio_out         = stb_q;
  assign left_channel_audio_out  = out_l_q;
  assign right_channel_audio_out = out_r_q;
  assign busy                    = (state_q != IDLE);

endmodule

// File: tb/tb_audio_tone_mixer.sv
// tb_audio_tone_mixer: scoreboard bench for audio_tone_mixer.
// Expected mixes are queued at capture and popped at each write strobe.
module tb_audio_tone_mixer;

  localparam int SW = 32;
  localparam int NT = 4;
  localparam int PW = 19;
  localparam int AW = SW - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NT*PW-1:0] hp;
  logic [NT*AW-1:0] amp;
  logic [2*NT-1:0]  route;
  logic          pt;
  logic          av, al;
  logic [SW-1:0] lin, rin;
  logic          rd, wr, busy;
  logic [SW-1:0] lout, rout;

  always #10 clk = ~clk;

  audio_tone_mixer #(.SAMPLE_W(SW), .NUM_TONES(NT), .PERIOD_W(PW)) dut (
    .CLOCK_50               (clk),
    .reset_n                (rst_n),
    .tone_half_period       (hp),
    .tone_amplitude         (amp),
    .tone_route             (route),
    .passthru_en            (pt),
    .audio_in_available     (av),
    .audio_out_allowed      (al),
    .left_channel_audio_in  (lin),
    .right_channel_audio_in (rin),
    .read_audio_in          (rd),
    .write_audio_out        (wr),
    .left_channel_audio_out (lout),
    .right_channel_audio_out(rout),
    .busy                   (busy)
  );

  int npass = 0;
  int nchk  = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nchk++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    else
      npass++;
  endtask

  typedef struct {
    logic [SW-1:0] l;
    logic [SW-1:0] r;
  } exp_t;

  exp_t q[$];
  int   mcnt [NT];
  bit   mpol [NT];
  bit   midle = 1'b1;
  bit   mexp  = 1'b0;
  int   mn    = 0;
  int   mstb  = 0;

  function automatic logic [SW-1:0] reduce(input longint v);
    logic [63:0] b;
`ifdef AUDIO_TONE_MIXER_SAT_EN
    if (v > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (v < -64'sd2147483648) return 32'h8000_0000;
`endif
    b = v;
    return b[SW-1:0];
  endfunction

  function automatic exp_t calc();
    exp_t   e;
    longint l, r, a;
    l = pt ? longint'($signed(lin)) : 0;
    r = pt ? longint'($signed(rin)) : 0;
    for (int k = 0; k < NT; k++) begin
      a = longint'(amp[k*AW +: AW]);
      if (hp[k*PW +: PW] != 0) begin
        if (route[2*k])   l += mpol[k] ? a : -a;
        if (route[2*k+1]) r += mpol[k] ? a : -a;
      end
    end
    e.l = reduce(l);
    e.r = reduce(r);
    return e;
  endfunction

  // Reference: tone counters plus capture/strobe timing.
  always @(posedge clk) begin
    if (!rst_n) begin
      midle = 1'b1;
      mn    = 0;
      mexp  = 1'b0;
      q.delete();
      for (int k = 0; k < NT; k++) begin
        mcnt[k] = 0;
        mpol[k] = 1'b0;
      end
    end else begin
      mexp = 1'b0;
      if (midle) begin
        if (av && al) begin
          q.push_back(calc());
          midle = 1'b0;
          mn    = 0;
        end
      end else begin
        if (mn >= 5 && av && al) begin
          midle = 1'b1;
          mexp  = 1'b1;
          mstb++;
        end
        mn++;
      end
      for (int k = 0; k < NT; k++) begin
        if (hp[k*PW +: PW] == 0) begin
          mcnt[k] = 0;
          mpol[k] = 1'b0;
        end else if (mcnt[k] >= int'(hp[k*PW +: PW])) begin
          mcnt[k] = 0;
          mpol[k] = ~mpol[k];
        end else begin
          mcnt[k]++;
        end
      end
    end
  end

  // Strobe and data checker.
  always @(negedge clk) begin
    exp_t e;
    if (rd || wr || mexp) begin
      chk("wr_stb", 64'(wr), 64'(mexp));
      chk("rd_stb", 64'(rd), 64'(mexp));
      if (mexp) begin
        if (q.size() == 0) begin
          chk("sb_empty", 64'd0, 64'd1);
        end else begin
          e = q.pop_front();
          chk("left", 64'(lout), 64'(e.l));
          chk("right", 64'(rout), 64'(e.r));
        end
      end
    end
  end

  task automatic set_tone(input int k, input int h, input int a);
    hp[k*PW +: PW]  = PW'(h);
    amp[k*AW +: AW] = AW'(a);
  endtask

  task automatic run(input int n);
    int target;
    target = mstb + n;
    av = 1'b1;
    al = 1'b1;
    for (int i = 0; i < n * 20 && mstb < target; i++) @(negedge clk);
    chk("run_done", 64'(mstb >= target), 64'd1);
    av = 1'b0;
    al = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    hp = '0; amp = '0; route = '0; pt = 1'b0;
    av = 1'b0; al = 1'b0; lin = '0; rin = '0;
    repeat (3) @(negedge clk);
    chk("rst_left", 64'(lout), 64'd0);
    chk("rst_right", 64'(rout), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_stb", 64'({rd, wr}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    set_tone(0, 3, 10000000);
    route = 8'b0000_0001;
    lin = 32'd100; rin = 32'd200; pt = 1'b1;
    run(6);

    for (int k = 0; k < NT; k++) set_tone(k, k + 2, 1000);
    route = 8'hFF; pt = 1'b0;
    run(6);

    for (int k = 1; k < NT; k++) set_tone(k, 0, 0);
    set_tone(0, 2, 1000);
    route = 8'b0000_0011; pt = 1'b1;
    lin = 32'h7FFF_FF00; rin = 32'h8000_0100;
    run(6);

    av = 1'b1; al = 1'b1;
    @(negedge clk);
    al = 1'b0;
    repeat (12) @(negedge clk);
    chk("bp_busy", 64'(busy), 64'd1);
    run(1);

    av = 1'b1; al = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_left", 64'(lout), 64'd0);
    chk("mid_right", 64'(rout), 64'd0);
    chk("mid_stb", 64'({rd, wr}), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    av = 1'b0; al = 1'b0;
    @(negedge clk);
    chk("rel_busy", 64'(busy), 64'd0);

    set_tone(0, 1000, 5000);
    lin = 32'd7; rin = -32'sd9;
    for (int i = 0; i < 2000 && mcnt[0] != 700; i++) @(negedge clk);
    chk("cnt_700", 64'(mcnt[0]), 64'd700);
    set_tone(0, 5, 5000);
    @(negedge clk);
    run(4);

    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
